// File: rtl/bias_weight_store.sv
// Parameter store: applies bias/weight delta packets one neuron per cycle, then publishes the set.
// Overflow handling: define BIAS_WEIGHT_STORE_SATURATE_EN to saturate; otherwise adds wrap.
module bias_weight_store #(
  parameter int NP = 4,
  parameter int NC = 4,
  parameter int WD = 4
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iMode,
  input  logic                         iValid_AS,
  output logic                         oReady_AS,
  input  logic [NC*WD+NC*NP*WD-1:0]    iData_AS,
  output logic                         oValid_BS,
  input  logic                         iReady_BS,
  output logic [NC*WD+NC*NP*WD-1:0]    oData_BS
);

  localparam int DW = NC*WD + NC*NP*WD;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_APPLY   = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   delta_q, delta_d;
  logic [DW-1:0]   param_q, param_d;

  function automatic logic [WD-1:0] add_sat(input logic [WD-1:0] a, input logic [WD-1:0] b);
    logic [WD-1:0] sum;
    sum = a + b;
`ifdef BIAS_WEIGHT_STORE_SATURATE_EN
    // Same-sign operands producing an opposite-sign result means overflow.
    if ((a[WD-1] == b[WD-1]) && (sum[WD-1] != a[WD-1])) begin
      sum = a[WD-1] ? {1'b1, {(WD-1){1'b0}}} : {1'b0, {(WD-1){1'b1}}};
    end
`endif
    return sum;
  endfunction

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      delta_q <= '0;
      param_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      delta_q <= delta_d;
      param_q <= param_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    delta_d = delta_q;
    param_d = param_q;
    case (state_q)
      S_INIT: state_d = S_PUBLISH;
      S_IDLE: begin
        // Inference-mode packets are accepted but never applied.
        if (iValid_AS && iMode) begin
          delta_d = iData_AS;
          idx_d   = '0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        for (int c = 0; c < NC; c++) begin
          if (idx_q == IW'(c)) begin
            param_d[c*WD +: WD] = add_sat(param_q[c*WD +: WD], delta_q[c*WD +: WD]);
            for (int p = 0; p < NP; p++) begin
              param_d[NC*WD + (c*NP+p)*WD +: WD] =
                add_sat(param_q[NC*WD + (c*NP+p)*WD +: WD], delta_q[NC*WD + (c*NP+p)*WD +: WD]);
            end
          end
        end
        if (idx_q == IW'(NC-1)) state_d = S_PUBLISH;
        else                    idx_d   = idx_q + IW'(1);
      end
      S_PUBLISH: if (iReady_BS) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  assign oReady_AS = (state_q == S_IDLE);
  assign oValid_BS = (state_q == S_PUBLISH);
  assign oData_BS  = param_q;

endmodule

// File: tb/tb_bias_weight_store.sv
// Scoreboard bench for bias_weight_store (NP=2, NC=2, WD=8); honours BIAS_WEIGHT_STORE_SATURATE_EN.
module tb_bias_weight_store;

  localparam int NP = 2;
  localparam int NC = 2;
  localparam int WD = 8;
  localparam int DW = NC*WD + NC*NP*WD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          vin = 1'b0;
  logic          rdy_as;
  logic [DW-1:0] din = '0;
  logic          vout;
  logic          rdy_bs = 1'b1;
  logic [DW-1:0] dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]          exp_q[$];
  logic [DW-1:0]          exp_v;
  logic signed [WD-1:0]   m_b [NC];
  logic signed [WD-1:0]   m_w [NC][NP];
  bit                     ok;

  bias_weight_store #(.NP(NP), .NC(NC), .WD(WD)) dut (
    .iCLK(clk), .iRST(rst), .iMode(mode), .iValid_AS(vin), .oReady_AS(rdy_as),
    .iData_AS(din), .oValid_BS(vout), .iReady_BS(rdy_bs), .oData_BS(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [WD-1:0] madd(input logic [WD-1:0] a, input logic [WD-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef BIAS_WEIGHT_STORE_SATURATE_EN
    if (s > (1 << (WD-1)) - 1) s = (1 << (WD-1)) - 1;
    if (s < -(1 << (WD-1)))    s = -(1 << (WD-1));
`endif
    return s[WD-1:0];
  endfunction

  function automatic logic [DW-1:0] pack_model();
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) begin
      v[c*WD +: WD] = m_b[c];
      for (int p = 0; p < NP; p++) v[NC*WD + (c*NP+p)*WD +: WD] = m_w[c][p];
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] mk_pkt(input int b0, input int b1, input int w00,
                                           input int w01, input int w10, input int w11);
    logic [DW-1:0] v;
    v = {w11[WD-1:0], w10[WD-1:0], w01[WD-1:0], w00[WD-1:0], b1[WD-1:0], b0[WD-1:0]};
    return v;
  endfunction

  task automatic model_zero();
    for (int c = 0; c < NC; c++) begin
      m_b[c] = '0;
      for (int p = 0; p < NP; p++) m_w[c][p] = '0;
    end
  endtask

  // Drives one packet for a single edge; training packets update the model and the scoreboard.
  task automatic send_update(input logic m, input logic [DW-1:0] d);
    vin = 1'b1; mode = m; din = d;
    @(posedge clk); #1;
    vin = 1'b0;
    if (m) begin
      for (int c = 0; c < NC; c++) begin
        m_b[c] = madd(m_b[c], d[c*WD +: WD]);
        for (int p = 0; p < NP; p++)
          m_w[c][p] = madd(m_w[c][p], d[NC*WD + (c*NP+p)*WD +: WD]);
      end
      exp_q.push_back(pack_model());
    end
  endtask

  task automatic wait_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (vout) begin found = 1'b1; return; end
      @(posedge clk); #1;
    end
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: publish seen with no expected set queued");
      exp_v = 'x;
    end else begin
      exp_v = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    model_zero();
    #2;
    checks++; if (vout !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b want 0", vout); end
    checks++; if (rdy_as !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", rdy_as); end
    checks++; if (dout !== '0)    begin errors++; $display("FAIL rst_data: got %h want 0", dout); end
    exp_q.push_back(pack_model());
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (vout !== 1'b1) begin errors++; $display("FAIL init_publish: valid got %b want 1", vout); end
    pop_exp();
    checks++; if (dout !== exp_v) begin errors++; $display("FAIL init_data: got %h want %h", dout, exp_v); end
    @(posedge clk); #1;
    checks++; if (rdy_as !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", rdy_as); end
    checks++; if (vout !== 1'b0)   begin errors++; $display("FAIL idle_valid: got %b want 0", vout); end
  endtask

  task automatic test_update();
    send_update(1'b1, mk_pkt(1, 2, 3, 3, 3, 3));
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL lat_edge1: valid got %b want 0", vout); end
    @(posedge clk); #1;
    checks++; if (vout !== 1'b0) begin errors++; $display("FAIL lat_edge2: valid got %b want 0", vout); end
    @(posedge clk); #1;
    checks++; if (vout !== 1'b1) begin errors++; $display("FAIL lat_edge3: valid got %b want 1", vout); end
    pop_exp();
    checks++; if (dout !== exp_v) begin errors++; $display("FAIL update_data: got %h want %h", dout, exp_v); end
    checks++;
    if (dout !== {8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1}) begin
      errors++; $display("FAIL update_const: got %h want 030303030201", dout);
    end
    @(posedge clk); #1;
    checks++; if (rdy_as !== 1'b1) begin errors++; $display("FAIL update_reaccept: ready got %b want 1", rdy_as); end
  endtask

  task automatic test_inference();
    send_update(1'b0, mk_pkt(1, 2, 3, 3, 3, 3));
    checks++; if (rdy_as !== 1'b1) begin errors++; $display("FAIL infer_ready: got %b want 1", rdy_as); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (vout !== 1'b0) begin errors++; $display("FAIL infer_valid[%0d]: got %b want 0", i, vout); end
      @(posedge clk); #1;
    end
    exp_v = pack_model();
    checks++; if (dout !== exp_v) begin errors++; $display("FAIL infer_data: got %h want %h", dout, exp_v); end
  endtask

  task automatic test_overflow();
    // Bring w00 to 120 and w01 to -120, then push both past the rails.
    send_update(1'b1, mk_pkt(0, 0, 117, -123, 0, 0));
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_pre_timeout: valid got 0 want 1"); end
    pop_exp();
    checks++; if (dout !== exp_v) begin errors++; $display("FAIL ovf_pre_data: got %h want %h", dout, exp_v); end
    @(posedge clk); #1;
    send_update(1'b1, mk_pkt(0, 0, 20, -20, 0, 0));
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: valid got 0 want 1"); end
    pop_exp();
    checks++; if (dout !== exp_v) begin errors++; $display("FAIL ovf_data: got %h want %h", dout, exp_v); end
`ifdef BIAS_WEIGHT_STORE_SATURATE_EN
    checks++; if (dout[23:16] !== 8'h7F) begin errors++; $display("FAIL ovf_pos_sat: got %h want 7f", dout[23:16]); end
    checks++; if (dout[31:24] !== 8'h80) begin errors++; $display("FAIL ovf_neg_sat: got %h want 80", dout[31:24]); end
`else
    checks++; if (dout[23:16] !== 8'h8C) begin errors++; $display("FAIL ovf_pos_wrap: got %h want 8c", dout[23:16]); end
    checks++; if (dout[31:24] !== 8'h74) begin errors++; $display("FAIL ovf_neg_wrap: got %h want 74", dout[31:24]); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    rdy_bs = 1'b0;
    send_update(1'b1, mk_pkt(-1, 5, 1, -2, 4, 0));
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: valid got 0 want 1"); end
    pop_exp();
    checks++; if (dout !== exp_v) begin errors++; $display("FAIL bp_data: got %h want %h", dout, exp_v); end
    vin = 1'b1; mode = 1'b1; din = mk_pkt(9, 9, 9, 9, 9, 9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (vout !== 1'b1)   begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, vout); end
      checks++; if (dout !== exp_v)  begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, dout, exp_v); end
      checks++; if (rdy_as !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, rdy_as); end
    end
    vin = 1'b0; rdy_bs = 1'b1;
    @(posedge clk); #1;
    checks++; if (vout !== 1'b0)   begin errors++; $display("FAIL bp_release_valid: got %b want 0", vout); end
    checks++; if (rdy_as !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", rdy_as); end
    checks++; if (dout !== exp_v)  begin errors++; $display("FAIL bp_release_data: got %h want %h", dout, exp_v); end
  endtask

  task automatic test_reset_apply();
    send_update(1'b1, mk_pkt(7, 7, 7, 7, 7, 7));
    rst = 1'b1;
    void'(exp_q.pop_back());
    model_zero();
    exp_q.push_back(pack_model());
    #1;
    checks++; if (dout !== '0)     begin errors++; $display("FAIL rst_apply_data: got %h want 0", dout); end
    checks++; if (vout !== 1'b0)   begin errors++; $display("FAIL rst_apply_valid: got %b want 0", vout); end
    checks++; if (rdy_as !== 1'b0) begin errors++; $display("FAIL rst_apply_ready: got %b want 0", rdy_as); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_apply_timeout: valid got 0 want 1"); end
    pop_exp();
    checks++; if (dout !== exp_v) begin errors++; $display("FAIL rst_apply_publish: got %h want %h", dout, exp_v); end
    @(posedge clk); #1;
    checks++; if (rdy_as !== 1'b1) begin errors++; $display("FAIL rst_apply_idle: ready got %b want 1", rdy_as); end
  endtask

  initial begin
    test_reset();
    test_update();
    test_inference();
    test_overflow();
    test_backpressure();
    test_reset_apply();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
